// File: rtl/oled_pkg.sv
// Shared definitions for the SSD1306 command sequencer: FSM states, error
// codes, i2c control bytes and the display power-up command table.
package oled_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,    // device address byte in flight
    CTRL,    // control byte in flight
    INIT,    // power-up table entries in flight
    STREAM,  // caller bytes in flight
    CLOSE    // enable dropped, waiting for the engine to release next
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  // SSD1306 control byte: Co=0, D/C#=0 for commands, D/C#=1 for GDDRAM data.
  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  localparam int unsigned INIT_TABLE_DEPTH = 16;

  // Display off, clock divide 0x80, multiplex 64, charge pump on, display on.
  localparam logic [7:0] INIT_TABLE [INIT_TABLE_DEPTH] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'h8D, 8'h14, 8'hAF,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/oled_cmd_sequencer_edge.sv
// i2c_next_edge: registers the engine's `next` request once, derives its
// rise/fall strobes, and runs the stall timer that restarts on every edge.
//
// Ports:
//   clock, reset_n  system clock, asynchronous active-low reset
//   next            engine `next` request (same clock domain)
//   run             timer counts when high, holds when low
//   clear           forces the timer to zero (sequencer not in a transfer)
//   rise, fall      single-cycle strobes for the edges of `next`
//   timeout         timer has reached TIMEOUT cycles without an edge
module i2c_next_edge #(
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic clock,
  input  logic reset_n,
  input  logic next,
  input  logic run,
  input  logic clear,
  output logic rise,
  output logic fall,
  output logic timeout
);

  logic        next_q;
  logic [15:0] timer_q;

  assign rise    = next & ~next_q;
  assign fall    = ~next & next_q;
  assign timeout = (timer_q == TIMEOUT);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values; blocking here would make results order-dependent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      next_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      next_q <= next;
      if (clear || rise || fall) begin
        timer_q <= '0;
      end else if (run && (timer_q != TIMEOUT)) begin
        // Saturate so a held timeout cannot wrap back to a quiet value.
        timer_q <= timer_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// oled_cmd_sequencer: drives a byte-level i2c engine for an SSD1306 OLED.
// One transaction sends the device address, a control byte, the power-up
// command table (command mode only) and then caller bytes until data_last.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   start, stream_mode    begin a transaction; mode selects command/data
//   data, data_valid,     caller byte stream; data_ready pulses when a byte
//   data_last, data_ready is consumed, data_last marks the final byte
//   i2c_enable, i2c_command, i2c_ack   to the i2c engine
//   i2c_next, i2c_trouble              from the i2c engine
//   busy, done, error     status: transfer active, success pulse, sticky cause
module oled_cmd_sequencer
  import oled_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h3C,
  parameter int unsigned INIT_LEN = 8,
  parameter logic [15:0] TIMEOUT  = 16'd4095
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stream_mode,
  input  logic [7:0] data,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       i2c_enable,
  output logic [7:0] i2c_command,
  output logic       i2c_ack,
  input  logic       i2c_next,
  input  logic       i2c_trouble,
  output logic       busy,
  output logic       done,
  output logic [1:0] error
);

  if (INIT_LEN < 1 || INIT_LEN > INIT_TABLE_DEPTH) begin : g_bad_init_len
    $error("oled_cmd_sequencer: INIT_LEN must be in 1..16");
  end

  localparam logic [3:0] LAST_IDX = 4'(INIT_LEN - 1);

  state_t     state_q, state_d;
  err_t       err_q,   err_d;
  logic [3:0] idx_q,   idx_d;
  logic [7:0] cmd_q,   cmd_d;
  logic       ack_q,   ack_d;
  logic       en_q,    en_d;
  logic       busy_q,  busy_d;
  logic       done_q,  done_d;
  logic       ready_q, ready_d;
  logic       mode_q,  mode_d;   // stream_mode captured at start
  logic       last_q,  last_d;   // byte in flight was flagged last
  logic       wait_q,  wait_d;   // engine is held while we wait for data_valid

  logic rise, fall, timeout;
  logic in_xfer, timer_run;
  logic close, fetch;

  // Transfer states are the ones where the engine owns the bus for us.
  assign in_xfer   = (state_q != IDLE) && (state_q != CLOSE);
  assign timer_run = ~wait_q;

  i2c_next_edge #(
    .TIMEOUT (TIMEOUT)
  ) u_next_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .next    (i2c_next),
    .run     (timer_run),
    .clear   (~in_xfer),
    .rise    (rise),
    .fall    (fall),
    .timeout (timeout)
  );

  // NOTE: every variable gets a default before any branch so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    ack_d   = ack_q;
    en_d    = en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ready_d = 1'b0;
    mode_d  = mode_q;
    last_d  = last_q;
    wait_d  = wait_q;
    close   = 1'b0;
    fetch   = 1'b0;

    // The engine has latched the byte once it drops next.
    if (fall) ack_d = 1'b0;

    // A NACK outranks both a stall and a simultaneous byte request.
    if (in_xfer && i2c_trouble) begin
      err_d = ERR_NACK;
      close = 1'b1;
    end else if (in_xfer && timeout) begin
      err_d = ERR_TIMEOUT;
      close = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            busy_d  = 1'b1;
            err_d   = ERR_NONE;
            cmd_d   = {DEV_ADDR, 1'b0};
            en_d    = 1'b1;
            ack_d   = 1'b0;
            mode_d  = stream_mode;
            idx_d   = '0;
            last_d  = 1'b0;
            wait_d  = 1'b0;
            state_d = OPEN;
          end
        end
        OPEN: begin
          if (rise) begin
            cmd_d   = mode_q ? CTRL_DATA : CTRL_CMD;
            ack_d   = 1'b1;
            state_d = CTRL;
          end
        end
        CTRL: begin
          if (rise) begin
            if (mode_q) begin
              state_d = STREAM;
              fetch   = 1'b1;
            end else begin
              cmd_d   = INIT_TABLE[0];
              ack_d   = 1'b1;
              idx_d   = '0;
              state_d = INIT;
            end
          end
        end
        INIT: begin
          if (rise) begin
            if (idx_q == LAST_IDX) begin
              // Data already waiting continues in the same transaction.
              if (data_valid) begin
                state_d = STREAM;
                fetch   = 1'b1;
              end else begin
                close = 1'b1;
              end
            end else begin
              cmd_d = INIT_TABLE[idx_q + 4'd1];
              ack_d = 1'b1;
              idx_d = idx_q + 4'd1;
            end
          end
        end
        STREAM: begin
          if (wait_q) begin
            fetch = 1'b1;
          end else if (rise) begin
            if (last_q) close = 1'b1;
            else        fetch = 1'b1;
          end
        end
        CLOSE: begin
          en_d  = 1'b0;
          ack_d = 1'b0;
          if (i2c_trouble && (err_q == ERR_NONE)) err_d = ERR_NACK;
          if (!i2c_next) begin
            done_d  = (err_d == ERR_NONE);
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (close) begin
      state_d = CLOSE;
      en_d    = 1'b0;
      ack_d   = 1'b0;
      wait_d  = 1'b0;
    end

    // Engine wants a stream byte: hand it over or park with ack low.
    if (fetch) begin
      if (data_valid) begin
        cmd_d   = data;
        ack_d   = 1'b1;
        ready_d = 1'b1;
        last_d  = data_last;
        wait_d  = 1'b0;
      end else begin
        wait_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      idx_q   <= '0;
      cmd_q   <= '0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
    end
  end

  assign i2c_enable  = en_q;
  assign i2c_command = cmd_q;
  assign i2c_ack     = ack_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign data_ready  = ready_q;
  assign error       = err_q;

endmodule
